// File: rtl/prog_loader.sv
// Boot-time program loader: turns a UART byte stream (4-byte header, instruction
// words, data words) into 128-bit instruction-memory and 32-bit data-memory writes.
module prog_loader #(
  parameter int ADDR_LEN       = 32,
  parameter int IMEM_WORDS_MAX = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [ADDR_LEN-1:0] ADDR,
  output logic [127:0]        DATA,
  output logic                WE_128,
  output logic                WE_32,
  output logic                DONE
);

  typedef enum logic [1:0] {HDR, IMEM, DMEM, FIN} state_t;

  state_t         state_q;
  logic [3:0]     byte_cnt_q;
  logic [15:0]    ni_q;
  logic [15:0]    nd_q;
  logic [15:0]    word_idx_q;
  logic [127:0]   asm_q;
  logic [127:0]   asm_d;

  logic [15:0]    ni_hdr;
  logic [15:0]    nd_hdr;
  logic [15:0]    ni_clamped;
  logic           last_imem;
  logic           last_dmem;
  logic [ADDR_LEN-1:0] imem_addr;
  logic [ADDR_LEN-1:0] dmem_addr;

  // The incoming byte merged into the assembly buffer; the completed word is
  // taken from here so the 16th (or 4th) byte needs no extra cycle.
  always_comb begin
    asm_d = asm_q;
    asm_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
  end

  assign ni_hdr     = asm_q[15:0];
  assign nd_hdr     = asm_d[31:16];
  assign ni_clamped = ({16'd0, ni_hdr} > 32'(IMEM_WORDS_MAX)) ? 16'(IMEM_WORDS_MAX) : ni_hdr;
  assign last_imem  = (word_idx_q == ni_q - 16'd1);
  assign last_dmem  = (word_idx_q == nd_q - 16'd1);
  assign imem_addr  = ADDR_LEN'({word_idx_q, 4'b0000});
  assign dmem_addr  = ADDR_LEN'({word_idx_q, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR;
      byte_cnt_q <= 4'd0;
      ni_q       <= 16'd0;
      nd_q       <= 16'd0;
      word_idx_q <= 16'd0;
      asm_q      <= 128'd0;
      ADDR       <= '0;
      DATA       <= 128'd0;
      WE_128     <= 1'b0;
      WE_32      <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      WE_128 <= 1'b0;
      WE_32  <= 1'b0;
      case (state_q)
        HDR: begin
          if (rx_valid) begin
            asm_q <= asm_d;
            if (byte_cnt_q == 4'd3) begin
              byte_cnt_q <= 4'd0;
              word_idx_q <= 16'd0;
              ni_q       <= ni_clamped;
              nd_q       <= nd_hdr;
              if (ni_clamped != 16'd0) begin
                state_q <= IMEM;
              end else if (nd_hdr != 16'd0) begin
                state_q <= DMEM;
              end else begin
                state_q <= FIN;
                DONE    <= 1'b1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 4'd1;
            end
          end
        end
        IMEM: begin
          if (rx_valid) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              WE_128 <= 1'b1;
              DATA   <= asm_d;
              ADDR   <= imem_addr;
              if (last_imem) begin
                word_idx_q <= 16'd0;
                state_q    <= (nd_q != 16'd0) ? DMEM : FIN;
              end else begin
                word_idx_q <= word_idx_q + 16'd1;
              end
            end
          end
        end
        DMEM: begin
          if (rx_valid) begin
            asm_q <= asm_d;
            if (byte_cnt_q == 4'd3) begin
              byte_cnt_q <= 4'd0;
              WE_32      <= 1'b1;
              DATA       <= {asm_d[31:0], 96'd0};
              ADDR       <= dmem_addr;
              if (last_dmem) begin
                state_q <= FIN;
              end else begin
                word_idx_q <= word_idx_q + 16'd1;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          // FIN reached via a write strobe: DONE follows one cycle behind it.
          DONE <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives byte streams and checks the recorded
// write strobes, addresses, data words and DONE timing against hand-computed values.
module tb_prog_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic [31:0]  ADDR;
  logic [127:0] DATA;
  logic         WE_128;
  logic         WE_32;
  logic         DONE;

  prog_loader #(.ADDR_LEN(32), .IMEM_WORDS_MAX(512)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ADDR(ADDR), .DATA(DATA), .WE_128(WE_128), .WE_32(WE_32), .DONE(DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;

  // Monitor: the only writer of these; tests index from a snapshot of the sizes.
  ev_t  q128[$];
  ev_t  q32[$];
  int   cyc = 0;
  int   done_rise = -1;
  int   both_cnt = 0;
  logic done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (WE_128 === 1'b1) q128.push_back('{cyc, ADDR, DATA});
      if (WE_32 === 1'b1)  q32.push_back('{cyc, ADDR, DATA});
      if (WE_128 === 1'b1 && WE_32 === 1'b1) both_cnt = both_cnt + 1;
      if (DONE === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
      done_prev = DONE;
    end
  end

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  tx_q[$];
  int          byte_cyc[$];

  task automatic drive(input int gap_max);
    byte_cyc.delete();
    for (int i = 0; i < tx_q.size(); i++) begin
      @(negedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = tx_q[i];
      byte_cyc.push_back(cyc);
      if (gap_max > 0) begin
        int gaps;
        gaps = $urandom_range(0, gap_max);
        repeat (gaps) begin
          @(negedge clk); #1;
          rx_valid = 1'b0;
        end
      end
    end
    @(negedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Junk byte offered during reset must be ignored.
  task automatic do_reset();
    @(negedge clk); #1;
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    repeat (2) @(negedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    #1;
    n_vec++; if (ADDR !== 32'd0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", ADDR); end
    n_vec++; if (DATA !== 128'd0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", DATA); end
    n_vec++; if (WE_128 !== 1'b0 || WE_32 !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b%b exp=00", WE_128, WE_32); end
    n_vec++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
    repeat (3) @(negedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (q128.size() != 0 || q32.size() != 0 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL reset_quiet got=%0d/%0d/%b exp=0/0/0", q128.size(), q32.size(), DONE);
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int b128, b32;
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    tx_q.delete();
    tx_q = '{8'h01, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'hAA); tx_q.push_back(8'hBB); tx_q.push_back(8'hCC); tx_q.push_back(8'hDD);
    drive(0);
    repeat (4) @(negedge clk);
    n_vec++; if (q128.size() - b128 != 1) begin n_bad++; $display("FAIL basic_n128 got=%0d exp=1", q128.size() - b128); end
    n_vec++; if (q32.size() - b32 != 1) begin n_bad++; $display("FAIL basic_n32 got=%0d exp=1", q32.size() - b32); end
    if (q128.size() > b128) begin
      n_vec++; if (q128[b128].addr !== 32'd0) begin n_bad++; $display("FAIL basic_iaddr got=%h exp=0", q128[b128].addr); end
      n_vec++; if (q128[b128].data !== 128'h0F0E0D0C0B0A09080706050403020100) begin
        n_bad++; $display("FAIL basic_idata got=%h exp=0f0e0d0c0b0a09080706050403020100", q128[b128].data);
      end
      n_vec++; if (q128[b128].cyc != byte_cyc[19] + 1) begin
        n_bad++; $display("FAIL basic_icyc got=%0d exp=%0d", q128[b128].cyc, byte_cyc[19] + 1);
      end
    end
    if (q32.size() > b32) begin
      n_vec++; if (q32[b32].addr !== 32'd0) begin n_bad++; $display("FAIL basic_daddr got=%h exp=0", q32[b32].addr); end
      n_vec++; if (q32[b32].data !== {32'hDDCCBBAA, 96'd0}) begin
        n_bad++; $display("FAIL basic_ddata got=%h exp=ddccbbaa000000000000000000000000", q32[b32].data);
      end
      n_vec++; if (q32[b32].cyc != byte_cyc[23] + 1) begin
        n_bad++; $display("FAIL basic_dcyc got=%0d exp=%0d", q32[b32].cyc, byte_cyc[23] + 1);
      end
    end
    n_vec++; if (done_rise != byte_cyc[23] + 2 || DONE !== 1'b1) begin
      n_bad++; $display("FAIL basic_done got=%0d/%b exp=%0d/1", done_rise, DONE, byte_cyc[23] + 2);
    end
    $display("test_basic: done");
  endtask

  task automatic test_empty();
    int b128, b32;
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    tx_q.delete();
    tx_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    drive(0);
    repeat (3) @(negedge clk);
    n_vec++; if (done_rise != byte_cyc[3] + 1) begin
      n_bad++; $display("FAIL empty_done_cyc got=%0d exp=%0d", done_rise, byte_cyc[3] + 1);
    end
    n_vec++; if (q128.size() != b128 || q32.size() != b32) begin
      n_bad++; $display("FAIL empty_strobes got=%0d/%0d exp=0/0", q128.size() - b128, q32.size() - b32);
    end
    n_vec++; if (DONE !== 1'b1 || ADDR !== 32'd0 || DATA !== 128'd0) begin
      n_bad++; $display("FAIL empty_hold got=%b/%h/%h exp=1/0/0", DONE, ADDR, DATA);
    end
    $display("test_empty: done");
  endtask

  task automatic test_gaps();
    int b128, b32;
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    tx_q.delete();
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 32; i++) tx_q.push_back(8'(8'h40 + i));
    drive(3);
    repeat (4) @(negedge clk);
    n_vec++; if (q128.size() - b128 != 2) begin n_bad++; $display("FAIL gaps_n128 got=%0d exp=2", q128.size() - b128); end
    n_vec++; if (q32.size() != b32) begin n_bad++; $display("FAIL gaps_n32 got=%0d exp=0", q32.size() - b32); end
    if (q128.size() - b128 >= 2) begin
      n_vec++; if (q128[b128].addr !== 32'h0 || q128[b128].data !== 128'h4F4E4D4C4B4A49484746454443424140) begin
        n_bad++; $display("FAIL gaps_w0 got=%h/%h exp=0/4f4e..4140", q128[b128].addr, q128[b128].data);
      end
      n_vec++; if (q128[b128+1].addr !== 32'h10 || q128[b128+1].data !== 128'h5F5E5D5C5B5A59585756555453525150) begin
        n_bad++; $display("FAIL gaps_w1 got=%h/%h exp=10/5f5e..5150", q128[b128+1].addr, q128[b128+1].data);
      end
      n_vec++; if (done_rise != q128[b128+1].cyc + 1) begin
        n_bad++; $display("FAIL gaps_done got=%0d exp=%0d", done_rise, q128[b128+1].cyc + 1);
      end
    end
    $display("test_gaps: done");
  endtask

  task automatic test_abort();
    int b128, b32;
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    tx_q.delete();
    tx_q = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h90, 8'h91, 8'h92, 8'h93, 8'h94, 8'h95, 8'h96};
    drive(0);
    do_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (q128.size() != b128 || q32.size() != b32 || DONE !== 1'b0) begin
      n_bad++; $display("FAIL abort_quiet got=%0d/%0d/%b exp=0/0/0", q128.size() - b128, q32.size() - b32, DONE);
    end
    $display("test_abort: partial load discarded, replaying basic");
    test_basic();
  endtask

  task automatic test_back_to_back_dmem();
    int b128, b32;
    logic [31:0] exp_w [3];
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    exp_w = '{32'h13121110, 32'h17161514, 32'h1B1A1918};
    tx_q.delete();
    tx_q = '{8'h00, 8'h00, 8'h03, 8'h00};
    for (int i = 0; i < 12; i++) tx_q.push_back(8'(8'h10 + i));
    drive(0);
    repeat (4) @(negedge clk);
    n_vec++; if (q32.size() - b32 != 3 || q128.size() != b128) begin
      n_bad++; $display("FAIL b2b_counts got=%0d/%0d exp=3/0", q32.size() - b32, q128.size() - b128);
    end
    if (q32.size() - b32 >= 3) begin
      for (int j = 0; j < 3; j++) begin
        n_vec++; if (q32[b32+j].addr !== 32'(4 * j) || q32[b32+j].data !== {exp_w[j], 96'd0}) begin
          n_bad++; $display("FAIL b2b_w%0d got=%h/%h exp=%h/%h", j, q32[b32+j].addr, q32[b32+j].data, 4 * j, {exp_w[j], 96'd0});
        end
      end
      n_vec++; if (done_rise != q32[b32+2].cyc + 1) begin
        n_bad++; $display("FAIL b2b_done got=%0d exp=%0d", done_rise, q32[b32+2].cyc + 1);
      end
    end
    $display("test_back_to_back_dmem: done");
  endtask

  task automatic test_clamp();
    int b128, b32, bad_addr;
    do_reset();
    b128 = q128.size(); b32 = q32.size();
    tx_q.delete();
    tx_q = '{8'hFF, 8'hFF, 8'h01, 8'h00};
    for (int i = 0; i < 512 * 16; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    drive(0);
    repeat (4) @(negedge clk);
    n_vec++; if (q128.size() - b128 != 512) begin n_bad++; $display("FAIL clamp_n128 got=%0d exp=512", q128.size() - b128); end
    if (q128.size() - b128 == 512) begin
      bad_addr = 0;
      for (int k = 0; k < 512; k++) if (q128[b128+k].addr !== 32'(16 * k)) bad_addr++;
      n_vec++; if (bad_addr != 0) begin n_bad++; $display("FAIL clamp_addr_seq got=%0d wrong exp=0 wrong", bad_addr); end
      n_vec++; if (q128[b128+511].addr !== 32'h1FF0 || q128[b128+511].data !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0) begin
        n_bad++; $display("FAIL clamp_last got=%h/%h exp=1ff0/fffefd..f1f0", q128[b128+511].addr, q128[b128+511].data);
      end
    end
    n_vec++; if (q32.size() - b32 != 1) begin n_bad++; $display("FAIL clamp_n32 got=%0d exp=1", q32.size() - b32); end
    else begin
      n_vec++; if (q32[b32].addr !== 32'd0 || q32[b32].data !== {32'h04030201, 96'd0}) begin
        n_bad++; $display("FAIL clamp_dword got=%h/%h exp=0/04030201", q32[b32].addr, q32[b32].data);
      end
    end
    n_vec++; if (DONE !== 1'b1) begin n_bad++; $display("FAIL clamp_done got=%b exp=1", DONE); end
    n_vec++; if (both_cnt != 0) begin n_bad++; $display("FAIL no_dual_strobe got=%0d exp=0", both_cnt); end
    $display("test_clamp: done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_gaps();
    test_abort();
    test_back_to_back_dmem();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
